// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and Data_Memory.
// Signal suffixes are named from the arbiter's point of view.
interface mem_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
);
    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic              p0_ack_o;
    logic [DATA_W-1:0] p0_data_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic              p1_ack_o;
    logic [DATA_W-1:0] p1_data_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    logic [1:0]        grant_o;
    logic              timeout_o;

    // Arbiter side
    modport slave (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  mem_ack_i, mem_data_i,
        output p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output grant_o, timeout_o
    );

    // Environment side (caches + memory)
    modport master (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output mem_ack_i, mem_data_i,
        input  p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the Data_Memory line port between the
// instruction cache (port 0) and the data cache (port 1), with a watchdog
// that aborts transactions the memory never acknowledges.
module mem_arbiter #(
    parameter int          DATA_W  = 256,
    parameter int          ADDR_W  = 32,
    parameter int          RR_MODE = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p0_data_q, p0_data_d;
    logic [DATA_W-1:0] p1_data_q, p1_data_d;
    logic [1:0]        grant_q, grant_d;
    logic              timeout_q, timeout_d;
    logic              pick;
    logic              finish;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        wdog_d       = wdog_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_data_d    = p0_data_q;
        p1_data_d    = p1_data_q;
        grant_d      = grant_q;
        timeout_d    = 1'b0;
        pick         = 1'b0;
        finish       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.p0_enable_i && bus.p1_enable_i) begin
                    pick = (RR_MODE != 0) ? ~last_q : 1'b0;
                end else begin
                    pick = bus.p1_enable_i;
                end
                if (bus.p0_enable_i || bus.p1_enable_i) begin
                    owner_d      = pick;
                    last_d       = pick;
                    grant_d      = pick ? 2'b10 : 2'b01;
                    mem_enable_d = 1'b1;
                    mem_write_d  = pick ? bus.p1_write_i : bus.p0_write_i;
                    mem_addr_d   = pick ? bus.p1_addr_i  : bus.p0_addr_i;
                    mem_data_d   = pick ? bus.p1_data_i  : bus.p0_data_i;
                    wdog_d       = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                finish = bus.mem_ack_i || (wdog_q == WD_W'(TIMEOUT - 1));
                if (finish) begin
                    mem_enable_d = 1'b0;
                    p0_ack_d     = ~owner_q;
                    p1_ack_d     = owner_q;
                    timeout_d    = ~bus.mem_ack_i;
                    if (bus.mem_ack_i && !mem_write_q) begin
                        if (owner_q) p1_data_d = bus.mem_data_i;
                        else         p0_data_d = bus.mem_data_i;
                    end
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            wdog_q       <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_data_q    <= '0;
            p1_data_q    <= '0;
            grant_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            wdog_q       <= wdog_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_data_q    <= p0_data_d;
            p1_data_q    <= p1_data_d;
            grant_q      <= grant_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.p0_ack_o     = p0_ack_q;
    assign bus.p1_ack_o     = p1_ack_q;
    assign bus.p0_data_o    = p0_data_q;
    assign bus.p1_data_o    = p1_data_q;
    assign bus.grant_o      = grant_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin/TIMEOUT 64 and
// fixed-priority/TIMEOUT 8) share one stimulus set; a transaction-level
// model of each is compared every cycle, plus directed sequences.
module tb_mem_arbiter;
    localparam int TMO_A = 64;
    localparam int TMO_B = 8;

    logic clk;
    logic rst;
    logic en0, en1, wr0, wr1, mack;
    logic [31:0]  a0, a1;
    logic [255:0] wd0, wd1, mdata;

    int passed = 0;
    int total  = 0;

    mem_arbiter_if #(.DATA_W(256), .ADDR_W(32)) ifa ();
    mem_arbiter_if #(.DATA_W(256), .ADDR_W(32)) ifb ();

    assign ifa.p0_enable_i = en0;  assign ifb.p0_enable_i = en0;
    assign ifa.p0_write_i  = wr0;  assign ifb.p0_write_i  = wr0;
    assign ifa.p0_addr_i   = a0;   assign ifb.p0_addr_i   = a0;
    assign ifa.p0_data_i   = wd0;  assign ifb.p0_data_i   = wd0;
    assign ifa.p1_enable_i = en1;  assign ifb.p1_enable_i = en1;
    assign ifa.p1_write_i  = wr1;  assign ifb.p1_write_i  = wr1;
    assign ifa.p1_addr_i   = a1;   assign ifb.p1_addr_i   = a1;
    assign ifa.p1_data_i   = wd1;  assign ifb.p1_data_i   = wd1;
    assign ifa.mem_ack_i   = mack; assign ifb.mem_ack_i   = mack;
    assign ifa.mem_data_i  = mdata; assign ifb.mem_data_i = mdata;

    mem_arbiter #(.DATA_W(256), .ADDR_W(32), .RR_MODE(1), .TIMEOUT(TMO_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa));
    mem_arbiter #(.DATA_W(256), .ADDR_W(32), .RR_MODE(0), .TIMEOUT(TMO_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- transaction-level reference model ----------------
    // Per instance d: whether a transaction is outstanding, who owns it,
    // how long it has waited, and the expected visible outputs.
    bit           busy    [2];
    bit           ackcyc  [2];
    int           waited  [2];
    int           owner   [2];
    int           last    [2];
    bit           e_en    [2];
    bit           e_wr    [2];
    logic [31:0]  e_addr  [2];
    logic [255:0] e_md    [2];
    logic [255:0] e_d0    [2];
    logic [255:0] e_d1    [2];
    bit           e_ack0  [2];
    bit           e_ack1  [2];
    bit           e_to    [2];
    logic [1:0]   e_grant [2];
    bit           model_live = 0;

    always @(posedge clk) begin
        int w;
        int lim;
        bit rr;
        for (int d = 0; d < 2; d++) begin
            lim = (d == 0) ? TMO_A : TMO_B;
            rr  = (d == 0);
            if (!rst) begin
                busy[d] = 0; ackcyc[d] = 0; waited[d] = 0; owner[d] = 0; last[d] = 1;
                e_en[d] = 0; e_wr[d] = 0; e_addr[d] = '0; e_md[d] = '0;
                e_d0[d] = '0; e_d1[d] = '0; e_ack0[d] = 0; e_ack1[d] = 0;
                e_to[d] = 0; e_grant[d] = '0;
            end else if (ackcyc[d]) begin
                ackcyc[d] = 0; e_ack0[d] = 0; e_ack1[d] = 0; e_to[d] = 0; e_grant[d] = '0;
            end else if (busy[d]) begin
                if (mack || waited[d] == lim - 1) begin
                    busy[d] = 0; ackcyc[d] = 1; e_en[d] = 0; e_to[d] = !mack;
                    if (owner[d] == 0) e_ack0[d] = 1; else e_ack1[d] = 1;
                    if (mack && !e_wr[d]) begin
                        if (owner[d] == 0) e_d0[d] = mdata; else e_d1[d] = mdata;
                    end
                end else begin
                    waited[d]++;
                end
            end else if (en0 || en1) begin
                if (en0 && en1) w = rr ? 1 - last[d] : 0;
                else            w = en1 ? 1 : 0;
                busy[d] = 1; waited[d] = 0; owner[d] = w; last[d] = w;
                e_en[d] = 1;
                e_grant[d] = (w == 1) ? 2'b10 : 2'b01;
                e_wr[d]    = (w == 1) ? wr1 : wr0;
                e_addr[d]  = (w == 1) ? a1  : a0;
                e_md[d]    = (w == 1) ? wd1 : wd0;
            end
        end
        model_live = 1;
    end

    task automatic cmp(input int d, input logic [6:0] ctrl, input logic [31:0] addr,
                       input logic [255:0] md, input logic [255:0] d0, input logic [255:0] d1);
        chk($sformatf("model%0d_ctrl", d), {249'd0, ctrl},
            {249'd0, e_en[d], e_wr[d], e_ack0[d], e_ack1[d], e_grant[d], e_to[d]});
        chk($sformatf("model%0d_addr", d), {224'd0, addr}, {224'd0, e_addr[d]});
        chk($sformatf("model%0d_mdata", d), md, e_md[d]);
        chk($sformatf("model%0d_p0data", d), d0, e_d0[d]);
        chk($sformatf("model%0d_p1data", d), d1, e_d1[d]);
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            cmp(0, {ifa.mem_enable_o, ifa.mem_write_o, ifa.p0_ack_o, ifa.p1_ack_o,
                    ifa.grant_o, ifa.timeout_o}, ifa.mem_addr_o, ifa.mem_data_o,
                ifa.p0_data_o, ifa.p1_data_o);
            cmp(1, {ifb.mem_enable_o, ifb.mem_write_o, ifb.p0_ack_o, ifb.p1_ack_o,
                    ifb.grant_o, ifb.timeout_o}, ifb.mem_addr_o, ifb.mem_data_o,
                ifb.p0_data_o, ifb.p1_data_o);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_en_a(input string nm);
        int n;
        n = 0;
        while (ifa.mem_enable_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {255'd0, ifa.mem_enable_o}, 256'd1);
    endtask

    task automatic settle(input int n);
        en0 = 0; en1 = 0; mack = 0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [1:0] en;     // {p1, p0}
        logic       wr;
        logic [1:0] gnt_a;  // round-robin instance
        logic [1:0] gnt_b;  // fixed-priority instance
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int rises;
        int acks;
        int n;
        logic [255:0] saved;

        vecs[0] = '{2'b11, 1'b0, 2'b01, 2'b01};
        vecs[1] = '{2'b11, 1'b1, 2'b10, 2'b01};
        vecs[2] = '{2'b01, 1'b0, 2'b01, 2'b01};
        vecs[3] = '{2'b11, 1'b0, 2'b10, 2'b01};
        vecs[4] = '{2'b10, 1'b1, 2'b10, 2'b10};
        vecs[5] = '{2'b11, 1'b0, 2'b01, 2'b01};
        vecs[6] = '{2'b11, 1'b1, 2'b10, 2'b01};
        vecs[7] = '{2'b10, 1'b0, 2'b10, 2'b10};

        rst = 0; en0 = 0; en1 = 0; wr0 = 0; wr1 = 0; mack = 0;
        a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; mdata = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_a_en",    {255'd0, ifa.mem_enable_o}, 256'd0);
        chk("rst_a_grant", {254'd0, ifa.grant_o}, 256'd0);
        chk("rst_a_p0d",   ifa.p0_data_o, 256'd0);
        chk("rst_b_p1d",   ifb.p1_data_o, 256'd0);
        rst = 1;
        @(negedge clk);

        // single read on port 1, ack after 10 cycles
        en1 = 1; wr1 = 0; a1 = 32'h400;
        wait_en_a("rd_grant");
        chk("rd_grant_o", {254'd0, ifa.grant_o}, 256'd2);
        chk("rd_addr", {224'd0, ifa.mem_addr_o}, 256'h400);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (ifa.mem_enable_o) cnt++;
            @(negedge clk);
        end
        if (ifa.mem_enable_o) cnt++;
        mack = 1; mdata = 256'h5;
        @(negedge clk);
        mack = 0; en1 = 0;
        chk("rd_en_cycles", 256'(cnt), 256'd10);
        chk("rd_en_drop", {255'd0, ifa.mem_enable_o}, 256'd0);
        chk("rd_p1_ack", {255'd0, ifa.p1_ack_o}, 256'd1);
        chk("rd_p0_ack", {255'd0, ifa.p0_ack_o}, 256'd0);
        chk("rd_p1_data", ifa.p1_data_o, 256'h5);
        @(negedge clk);
        chk("rd_ack_pulse", {255'd0, ifa.p1_ack_o}, 256'd0);
        settle(20);

        // arbitration table: round-robin vs fixed priority
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en0 = vecs[i].en[0]; en1 = vecs[i].en[1];
            wr0 = vecs[i].wr; wr1 = vecs[i].wr;
            a0 = 32'h100 + i; a1 = 32'h200 + i;
            wd0 = 256'(i + 16); wd1 = 256'(i + 32);
            wait_en_a($sformatf("tbl%0d_en", i));
            chk($sformatf("tbl%0d_gnt_a", i), {254'd0, ifa.grant_o}, {254'd0, vecs[i].gnt_a});
            chk($sformatf("tbl%0d_gnt_b", i), {254'd0, ifb.grant_o}, {254'd0, vecs[i].gnt_b});
            @(negedge clk);
            mack = 1; mdata = 256'(i + 100);
            @(negedge clk);
            mack = 0;
            chk($sformatf("tbl%0d_ack_a", i), {254'd0, ifa.p1_ack_o, ifa.p0_ack_o},
                {254'd0, vecs[i].gnt_a});
            chk($sformatf("tbl%0d_ack_b", i), {254'd0, ifb.p1_ack_o, ifb.p0_ack_o},
                {254'd0, vecs[i].gnt_b});
            en0 = 0; en1 = 0;
        end

        // write then read of the same line
        @(negedge clk);
        saved = e_d0[0];
        en0 = 1; wr0 = 1; a0 = 32'h20; wd0 = 256'hDEAD;
        wait_en_a("wr_en");
        chk("wr_mem_write", {255'd0, ifa.mem_write_o}, 256'd1);
        chk("wr_mem_data", ifa.mem_data_o, 256'hDEAD);
        chk("wr_addr", {224'd0, ifa.mem_addr_o}, 256'h20);
        @(negedge clk);
        mack = 1; mdata = 256'hBAD;
        @(negedge clk);
        mack = 0;
        chk("wr_p0_ack", {255'd0, ifa.p0_ack_o}, 256'd1);
        chk("wr_p0_data_held", ifa.p0_data_o, saved);
        en0 = 0; en1 = 1; wr1 = 0; a1 = 32'h20;
        wait_en_a("rd2_en");
        chk("rd2_mem_write", {255'd0, ifa.mem_write_o}, 256'd0);
        @(negedge clk);
        mack = 1; mdata = 256'hDEAD;
        @(negedge clk);
        mack = 0; en1 = 0;
        chk("rd2_p1_ack", {255'd0, ifa.p1_ack_o}, 256'd1);
        chk("rd2_p1_data", ifa.p1_data_o, 256'hDEAD);
        settle(3);

        // owner holds enable through DONE; ack in IDLE ignored
        @(negedge clk);
        en0 = 1; wr0 = 0; a0 = 32'h40;
        wait_en_a("hold_en");
        @(negedge clk);
        mack = 1; mdata = 256'h77;
        @(negedge clk);
        mack = 0;
        chk("hold_ack", {255'd0, ifa.p0_ack_o}, 256'd1);
        @(negedge clk);
        en0 = 0;
        rises = 0; acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifa.mem_enable_o) rises++;
            if (ifa.p0_ack_o || ifa.p1_ack_o) acks++;
            mack = (i == 0);
        end
        mack = 0;
        chk("hold_no_regrant", 256'(rises), 256'd0);
        chk("idle_ack_ignored", 256'(acks), 256'd0);
        en0 = 1;
        wait_en_a("hold_reassert");
        @(negedge clk);
        mack = 1;
        @(negedge clk);
        mack = 0; en0 = 0;
        settle(20);

        // watchdog abort on the TIMEOUT=8 instance
        @(negedge clk);
        saved = e_d0[1];
        en0 = 1; wr0 = 0; a0 = 32'h80;
        n = 0;
        while (ifb.mem_enable_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cnt = 0; n = 0;
        while (ifb.mem_enable_o === 1'b1 && n < 20) begin
            cnt++;
            @(negedge clk);
            n++;
        end
        chk("to_en_cycles", 256'(cnt), 256'd8);
        chk("to_p0_ack", {255'd0, ifb.p0_ack_o}, 256'd1);
        chk("to_pulse", {255'd0, ifb.timeout_o}, 256'd1);
        chk("to_p0_data_held", ifb.p0_data_o, saved);
        chk("to_a_still_waiting", {255'd0, ifa.mem_enable_o}, 256'd1);
        en0 = 0;
        @(negedge clk);
        chk("to_pulse_end", {255'd0, ifb.timeout_o}, 256'd0);
        @(negedge clk);
        mack = 1; mdata = 256'h99;
        @(negedge clk);
        mack = 0;
        chk("to_a_ack", {255'd0, ifa.p0_ack_o}, 256'd1);
        chk("to_a_no_timeout", {255'd0, ifa.timeout_o}, 256'd0);
        chk("to_b_idle_ack", {255'd0, ifb.p0_ack_o}, 256'd0);
        settle(20);

        // reset in the middle of ISSUE
        @(negedge clk);
        en1 = 1; wr1 = 1; a1 = 32'h99; wd1 = 256'h1234;
        wait_en_a("rst_mid_en");
        @(negedge clk);
        rst = 0; en1 = 0;
        @(negedge clk);
        rst = 1;
        chk("rstmid_en", {255'd0, ifa.mem_enable_o}, 256'd0);
        chk("rstmid_grant", {254'd0, ifa.grant_o}, 256'd0);
        chk("rstmid_addr", {224'd0, ifa.mem_addr_o}, 256'd0);
        chk("rstmid_mdata", ifa.mem_data_o, 256'd0);
        chk("rstmid_p1d", ifa.p1_data_o, 256'd0);
        @(negedge clk);
        mack = 1;
        @(negedge clk);
        mack = 0;
        chk("rstmid_late_ack", {254'd0, ifa.p1_ack_o, ifa.p0_ack_o}, 256'd0);
        settle(20);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) != 0);
            en0   = $urandom_range(0, 2) != 0;
            en1   = $urandom_range(0, 2) != 0;
            wr0   = $urandom_range(0, 1) != 0;
            wr1   = $urandom_range(0, 1) != 0;
            a0    = $urandom;
            a1    = $urandom;
            wd0   = rnd256();
            wd1   = rnd256();
            mack  = ($urandom_range(0, 5) == 0);
            mdata = rnd256();
        end
        rst = 1;
        settle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
